load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage access engine placed between the EX/MEM pipeline register and a multi-cycle data bus. It replaces the single-cycle data memory path.
- Takes address, store data and funct3 from the MEM stage.
- Runs a req/ready bus handshake and produces byte-strobed stores and sign/zero-extended loads.
- Stalls the pipeline through the hazard unit until the access completes.
- Reports misaligned or illegal accesses and bus timeouts.

Parameters:
ADDR_W, 32, address width of ALUResultM and bus_addr
TIMEOUT, 16, maximum BUSY cycles without bus_ready before a timeout error is reported
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  pipeline clock; all state changes on the rising edge
rst  in  1  synchronous active-low reset; rst==0 at a rising edge resets the block
MemReadM  in  1  MEM-stage instruction is a load
MemWriteM  in  1  MEM-stage instruction is a store
funct3M  in  3  access size/sign, RISC-V encoding
ALUResultM  in  ADDR_W  byte address
WriteDataM  in  32  store data, right-aligned
bus_req  out  1  bus request, held until accepted
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address, with [1:0] forced to 0
bus_wdata  out  32  store data, lane-replicated
bus_wstrb  out  4  byte enables; 0 on reads
bus_ready  in  1  bus completes the access in this cycle
bus_rdata  in  32  read word, valid when bus_ready==1
ReadDataM  out  32  extended load result, valid in DONE
StallM  out  1  freezes the F/D/E/M pipeline registers
AccessErrM  out  1  one-cycle pulse: misaligned or illegal funct3
TimeoutM  out  1  one-cycle pulse: bus did not respond within TIMEOUT cycles

Behaviour:
Reset:
- rst==0 at an edge: state=IDLE, counter=0, rdata register=0.
- All outputs are 0 during and after reset, including StallM and bus_req.
- Reset applied in BUSY drops bus_req at that same edge; the pending access is abandoned.

Request:
- req = MemReadM | MemWriteM.
- If both are 1, treat the access as a store.

Legality:
- Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: funct3 000 SB, 001 SH, 010 SW.
- Any other funct3 is illegal.
- Misaligned: halfword with addr[0]==1, or word with addr[1:0]!=0.

State machine (IDLE, BUSY, DONE):
- IDLE:
  - StallM = req, combinational.
  - req & legal -> BUSY; the bus_* outputs are registered from the inputs.
  - req & !legal -> DONE, with AccessErrM=1 for the DONE cycle and no bus activity.
- BUSY:
  - bus_req=1 and StallM=1; the counter increments each cycle.
  - bus_ready==1 -> DONE; bus_rdata is captured, bus_req=0 from the next cycle.
  - counter==TIMEOUT-1 and bus_ready==0 -> DONE with TimeoutM=1; captured data=0, bus_req dropped.
  - bus_ready wins over timeout when both occur in the same cycle.
- DONE:
  - StallM=0, so the pipeline advances.
  - ReadDataM is valid for loads and 0 for stores and errors.
  - Next state is always IDLE, which prevents re-issue of the same instruction. The next request is evaluated in IDLE on the following cycle.

Latency:
- Zero-wait bus (bus_ready in the first BUSY cycle): the load occupies MEM for 3 cycles (IDLE, BUSY, DONE), and StallM is high for 2 of them.
- Each wait cycle adds 1.
- Error path: StallM high for 1 cycle.

Store lanes (o = addr[1:0]):
- SB: wdata = {4{WriteDataM[7:0]}}, wstrb = 0001 << o.
- SH: wdata = {2{WriteDataM[15:0]}}, wstrb = 0011 << o.
- SW: wdata = WriteDataM, wstrb = 1111.

Load extraction:
- Select the byte/half at offset o from the captured word.
- LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- funct3 and o are latched at IDLE->BUSY and used in DONE.

Stability:
- bus_addr, bus_we, bus_wdata and bus_wstrb are held constant throughout BUSY.
- These outputs are 0 outside BUSY.

No request: IDLE holds, with StallM=0 and bus_req=0.

Test Plan:
1. Reset: hold rst=0 for 2 cycles while MemReadM=1 -> StallM=0, bus_req=0, ReadDataM=0; first request is seen in the cycle after rst=1.
2. LB, addr 0x103, bus_rdata 0x80FF_1234, zero-wait -> bus_addr=0x100, wstrb=0000, ReadDataM=0xFFFF_FF80 in DONE; StallM high exactly 2 cycles.
3. SH, addr 0x22, WriteDataM 0x0000_BEEF, bus_ready after 3 waits -> bus_wdata=0xBEEF_BEEF, wstrb=1100, bus_req high 4 cycles with fields stable; StallM=0 in DONE.
4. LW, addr 0x6 (misaligned), and separately load funct3=011 -> no bus_req, AccessErrM pulses once, StallM high 1 cycle, ReadDataM=0.
5. LHU, addr 0x40, bus_ready never asserted, TIMEOUT=16 -> TimeoutM pulses after 16 BUSY cycles, ReadDataM=0, back to IDLE; separately, bus_ready and timeout in the same cycle -> data taken, no TimeoutM.
6. Reset mid-access: drive rst=0 in the 2nd BUSY cycle -> bus_req=0 and state=IDLE at that edge; back-to-back LW then SW each issue exactly one bus access.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: runs a req/ready bus handshake, builds byte-strobed
// stores and extended loads, and stalls the pipeline until the access completes.
module load_store_unit #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [2:0]        funct3M,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [31:0]       WriteDataM,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_wstrb,
   input  logic              bus_ready,
   input  logic [31:0]       bus_rdata,
   output logic [31:0]       ReadDataM,
   output logic              StallM,
   output logic              AccessErrM,
   output logic              TimeoutM
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} lsuStateT;

   lsuStateT          stateQ;
   logic [CNT_W-1:0]  cntQ;
   logic [31:0]       rdataQ;
   logic [2:0]        funct3Q;
   logic [1:0]        offQ;
   logic              loadQ;
   logic              busReqQ;
   logic              busWeQ;
   logic [ADDR_W-1:0] busAddrQ;
   logic [31:0]       busWdataQ;
   logic [3:0]        busWstrbQ;
   logic              accessErrQ;
   logic              timeoutQ;

   logic              req;
   logic              isStore;
   logic              legalF3;
   logic              misaligned;
   logic              legal;
   logic              timeoutHit;
   logic [31:0]       laneWdata;
   logic [3:0]        laneWstrb;
   logic [31:0]       shifted;
   logic [31:0]       extData;

   always_comb begin
      req     = MemReadM | MemWriteM;
      isStore = MemWriteM;  // a simultaneous read+write is treated as a store
      if (isStore) begin
         legalF3 = funct3M inside {3'b000, 3'b001, 3'b010};
      end else begin
         legalF3 = funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      misaligned = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                   ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
      legal      = legalF3 & ~misaligned;
      timeoutHit = (cntQ == CNT_W'(TIMEOUT - 1));
   end

   always_comb begin
      laneWdata = WriteDataM;
      laneWstrb = 4'b1111;
      case (funct3M[1:0])
         2'b00: begin
            laneWdata = {4{WriteDataM[7:0]}};
            laneWstrb = 4'b0001 << ALUResultM[1:0];
         end
         2'b01: begin
            laneWdata = {2{WriteDataM[15:0]}};
            laneWstrb = 4'b0011 << ALUResultM[1:0];
         end
         default: begin
            laneWdata = WriteDataM;
            laneWstrb = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stateQ     <= StIdle;
         cntQ       <= '0;
         rdataQ     <= '0;
         funct3Q    <= '0;
         offQ       <= '0;
         loadQ      <= 1'b0;
         busReqQ    <= 1'b0;
         busWeQ     <= 1'b0;
         busAddrQ   <= '0;
         busWdataQ  <= '0;
         busWstrbQ  <= '0;
         accessErrQ <= 1'b0;
         timeoutQ   <= 1'b0;
      end else begin
         accessErrQ <= 1'b0;
         timeoutQ   <= 1'b0;
         unique case (stateQ)
            StIdle: begin
               if (req) begin
                  funct3Q <= funct3M;
                  offQ    <= ALUResultM[1:0];
                  cntQ    <= '0;
                  rdataQ  <= '0;
                  if (legal) begin
                     stateQ    <= StBusy;
                     loadQ     <= ~isStore;
                     busReqQ   <= 1'b1;
                     busWeQ    <= isStore;
                     busAddrQ  <= {ALUResultM[ADDR_W-1:2], 2'b00};
                     busWdataQ <= isStore ? laneWdata : 32'h0;
                     busWstrbQ <= isStore ? laneWstrb : 4'b0000;
                  end else begin
                     stateQ     <= StDone;
                     loadQ      <= 1'b0;
                     accessErrQ <= 1'b1;
                  end
               end
            end
            StBusy: begin
               cntQ <= cntQ + 1'b1;
               // bus_ready takes priority over a same-cycle timeout
               if (bus_ready || timeoutHit) begin
                  stateQ    <= StDone;
                  rdataQ    <= bus_ready ? bus_rdata : 32'h0;
                  timeoutQ  <= ~bus_ready;
                  busReqQ   <= 1'b0;
                  busWeQ    <= 1'b0;
                  busAddrQ  <= '0;
                  busWdataQ <= '0;
                  busWstrbQ <= '0;
               end
            end
            StDone: begin
               stateQ <= StIdle;
            end
            default: begin
               stateQ <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      shifted = rdataQ >> {offQ, 3'b000};
      case (funct3Q)
         3'b000:  extData = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  extData = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  extData = {24'h0, shifted[7:0]};
         3'b101:  extData = {16'h0, shifted[15:0]};
         default: extData = rdataQ;
      endcase
   end

   assign ReadDataM  = ((stateQ == StDone) && loadQ) ? extData : 32'h0;
   assign StallM     = rst & (((stateQ == StIdle) && req) || (stateQ == StBusy));
   assign bus_req    = busReqQ;
   assign bus_we     = busWeQ;
   assign bus_addr   = busAddrQ;
   assign bus_wdata  = busWdataQ;
   assign bus_wstrb  = busWstrbQ;
   assign AccessErrM = accessErrQ;
   assign TimeoutM   = timeoutQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a reactive bus model plus hand-computed expectations.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemReadM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        busReady;
   logic [31:0] busRdata;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        AccessErrM;
   logic        TimeoutM;

   int checks = 0;
   int errors = 0;

   // Observations collected by runAccess
   int          obsStall, obsReq, obsAcc, obsErr, obsTo, obsCycles;
   logic        obsDone, obsUnstable, obsWe;
   logic [31:0] obsRd, obsAddr, obsWdata;
   logic [3:0]  obsStrb;

   load_store_unit dut (
      .clk        (clk),
      .rst        (rst),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wstrb  (bus_wstrb),
      .bus_ready  (busReady),
      .bus_rdata  (busRdata),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .AccessErrM (AccessErrM),
      .TimeoutM   (TimeoutM)
   );

   always #5 clk = ~clk;

   task automatic sampleCycle(inout logic prevReq);
      if (StallM) obsStall++;
      if (AccessErrM) obsErr++;
      if (TimeoutM) obsTo++;
      if (bus_req) begin
         if (!prevReq) begin
            obsAcc++;
            obsAddr  = bus_addr;
            obsWdata = bus_wdata;
            obsStrb  = bus_wstrb;
            obsWe    = bus_we;
         end else if (bus_addr !== obsAddr || bus_wdata !== obsWdata ||
                      bus_wstrb !== obsStrb || bus_we !== obsWe) begin
            obsUnstable = 1'b1;
         end
         obsReq++;
      end
      prevReq = bus_req;
   endtask

   // Called at drive time (just after a rising edge, state IDLE). Holds the instruction until
   // DONE, with bus_ready raised on BUSY cycle waits+1 (never if waits < 0).
   task automatic runAccess(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] rdata);
      int   waitCnt;
      logic prevReq;
      obsStall = 0; obsReq = 0; obsAcc = 0; obsErr = 0; obsTo = 0; obsCycles = 0;
      obsDone = 1'b0; obsUnstable = 1'b0; obsWe = 1'b0;
      obsRd = '0; obsAddr = '0; obsWdata = '0; obsStrb = '0;
      MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
      busReady = 1'b0; busRdata = 32'h5A5A_5A5A;
      waitCnt = 0; prevReq = 1'b0;
      for (int n = 0; n < 40 && !obsDone; n++) begin
         @(negedge clk);
         obsCycles++;
         sampleCycle(prevReq);
         if (!StallM) begin
            obsDone = 1'b1;
            obsRd   = ReadDataM;
         end
         @(posedge clk);
         #1;
         if (obsDone) begin
            MemReadM = 1'b0; MemWriteM = 1'b0;
            busReady = 1'b0;
         end else if (bus_req) begin
            busReady = (waits >= 0) && (waitCnt == waits);
            busRdata = busReady ? rdata : 32'h5A5A_5A5A;
            waitCnt++;
         end else begin
            busReady = 1'b0;
         end
      end
      MemReadM = 1'b0; MemWriteM = 1'b0; busReady = 1'b0;
      @(negedge clk);
      sampleCycle(prevReq);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
      ALUResultM = 32'h0; WriteDataM = 32'h0; busReady = 1'b0; busRdata = 32'h0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (StallM !== 1'b0 || bus_req !== 1'b0 || ReadDataM !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b req=%b rd=%h required 0 0 0",
                     StallM, bus_req, ReadDataM);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (StallM !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_req_stall: got %b required 1", StallM);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_first_req_bus: req=%b addr=%h required 1 0", bus_req, bus_addr);
      end
      busReady = 1'b1; busRdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      busReady = 1'b0;
      @(negedge clk);
      checks++;
      if (StallM !== 1'b0 || ReadDataM !== 32'h1234_5678) begin
         errors++;
         $display("FAIL reset_first_lw: stall=%b rd=%h required 0 12345678", StallM, ReadDataM);
      end
      @(posedge clk);
      #1;
      MemReadM = 1'b0;
   endtask

   task automatic test_load_byte;
      runAccess(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_1234);
      checks++;
      if (obsAddr !== 32'h100 || obsStrb !== 4'b0000 || obsWe !== 1'b0) begin
         errors++;
         $display("FAIL lb_bus: addr=%h strb=%b we=%b required 100 0000 0", obsAddr, obsStrb, obsWe);
      end
      checks++;
      if (obsRd !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL lb_data: got %h required ffffff80", obsRd);
      end
      checks++;
      if (obsStall != 2 || obsCycles != 3 || obsAcc != 1) begin
         errors++;
         $display("FAIL lb_latency: stall=%0d cycles=%0d acc=%0d required 2 3 1",
                  obsStall, obsCycles, obsAcc);
      end
      runAccess(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 0, 32'h8765_0000);
      checks++;
      if (obsRd !== 32'hFFFF_8765) begin
         errors++;
         $display("FAIL lh_data: got %h required ffff8765", obsRd);
      end
      runAccess(1'b1, 1'b0, 3'b100, 32'h1, 32'h0, 1, 32'h0000_F000);
      checks++;
      if (obsRd !== 32'h0000_00F0 || obsStall != 3) begin
         errors++;
         $display("FAIL lbu_data: rd=%h stall=%0d required 000000f0 3", obsRd, obsStall);
      end
   endtask

   task automatic test_store;
      runAccess(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 3, 32'h0);
      checks++;
      if (obsWdata !== 32'hBEEF_BEEF || obsStrb !== 4'b1100 || obsWe !== 1'b1 ||
          obsAddr !== 32'h20) begin
         errors++;
         $display("FAIL sh_bus: wdata=%h strb=%b we=%b addr=%h required beefbeef 1100 1 20",
                  obsWdata, obsStrb, obsWe, obsAddr);
      end
      checks++;
      if (obsReq != 4 || obsUnstable !== 1'b0 || obsStall != 5 || !obsDone || obsRd !== 32'h0) begin
         errors++;
         $display("FAIL sh_timing: req=%0d unstable=%b stall=%0d done=%b rd=%h required 4 0 5 1 0",
                  obsReq, obsUnstable, obsStall, obsDone, obsRd);
      end
      runAccess(1'b0, 1'b1, 3'b000, 32'h1, 32'h1234_5678, 0, 32'h0);
      checks++;
      if (obsWdata !== 32'h7878_7878 || obsStrb !== 4'b0010) begin
         errors++;
         $display("FAIL sb_lanes: wdata=%h strb=%b required 78787878 0010", obsWdata, obsStrb);
      end
      runAccess(1'b1, 1'b1, 3'b010, 32'h8, 32'hCAFE_BABE, 0, 32'hFFFF_FFFF);
      checks++;
      if (obsWe !== 1'b1 || obsStrb !== 4'b1111 || obsWdata !== 32'hCAFE_BABE || obsRd !== 32'h0) begin
         errors++;
         $display("FAIL rw_as_store: we=%b strb=%b wdata=%h rd=%h required 1 1111 cafebabe 0",
                  obsWe, obsStrb, obsWdata, obsRd);
      end
   endtask

   task automatic test_access_error;
      runAccess(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 0, 32'h1111_1111);
      checks++;
      if (obsReq != 0 || obsErr != 1 || obsStall != 1 || obsRd !== 32'h0 || obsTo != 0) begin
         errors++;
         $display("FAIL lw_misaligned: req=%0d err=%0d stall=%0d rd=%h to=%0d required 0 1 1 0 0",
                  obsReq, obsErr, obsStall, obsRd, obsTo);
      end
      runAccess(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h1111_1111);
      checks++;
      if (obsReq != 0 || obsErr != 1 || obsStall != 1 || obsRd !== 32'h0) begin
         errors++;
         $display("FAIL load_f3_011: req=%0d err=%0d stall=%0d rd=%h required 0 1 1 0",
                  obsReq, obsErr, obsStall, obsRd);
      end
      runAccess(1'b0, 1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, 0, 32'h0);
      checks++;
      if (obsReq != 0 || obsErr != 1 || obsStall != 1) begin
         errors++;
         $display("FAIL store_f3_100: req=%0d err=%0d stall=%0d required 0 1 1",
                  obsReq, obsErr, obsStall);
      end
   endtask

   task automatic test_timeout;
      runAccess(1'b1, 1'b0, 3'b101, 32'h40, 32'h0, -1, 32'h0);
      checks++;
      if (obsTo != 1 || obsReq != 16 || obsRd !== 32'h0 || obsCycles != 18 || obsErr != 0) begin
         errors++;
         $display("FAIL lhu_timeout: to=%0d req=%0d rd=%h cycles=%0d err=%0d required 1 16 0 18 0",
                  obsTo, obsReq, obsRd, obsCycles, obsErr);
      end
      runAccess(1'b1, 1'b0, 3'b101, 32'h42, 32'h0, 15, 32'h8001_0000);
      checks++;
      if (obsTo != 0 || obsReq != 16 || obsRd !== 32'h0000_8001) begin
         errors++;
         $display("FAIL ready_beats_timeout: to=%0d req=%0d rd=%h required 0 16 00008001",
                  obsTo, obsReq, obsRd);
      end
   endtask

   task automatic test_reset_mid_access;
      MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h10;
      busReady = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus_req !== 1'b1) begin
         errors++;
         $display("FAIL midrst_busy: req=%b required 1", bus_req);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (StallM !== 1'b0) begin
         errors++;
         $display("FAIL midrst_stall_during: got %b required 0", StallM);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin
         errors++;
         $display("FAIL midrst_drop: req=%b addr=%h required 0 0", bus_req, bus_addr);
      end
      rst = 1'b1; MemReadM = 1'b0;
      @(negedge clk);
      checks++;
      if (StallM !== 1'b0 || bus_req !== 1'b0 || ReadDataM !== 32'h0 || TimeoutM !== 1'b0) begin
         errors++;
         $display("FAIL midrst_idle: stall=%b req=%b rd=%h to=%b required 0 0 0 0",
                  StallM, bus_req, ReadDataM, TimeoutM);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      runAccess(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 0, 32'hA5A5_0F0F);
      checks++;
      if (obsAcc != 1 || obsRd !== 32'hA5A5_0F0F || obsCycles != 3) begin
         errors++;
         $display("FAIL b2b_lw: acc=%0d rd=%h cycles=%0d required 1 a5a50f0f 3",
                  obsAcc, obsRd, obsCycles);
      end
      runAccess(1'b0, 1'b1, 3'b010, 32'h34, 32'h1122_3344, 1, 32'h0);
      checks++;
      if (obsAcc != 1 || obsWdata !== 32'h1122_3344 || obsStrb !== 4'b1111 ||
          obsAddr !== 32'h34 || obsReq != 2) begin
         errors++;
         $display("FAIL b2b_sw: acc=%0d wdata=%h strb=%b addr=%h req=%0d required 1 11223344 1111 34 2",
                  obsAcc, obsWdata, obsStrb, obsAddr, obsReq);
      end
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_store();
      test_access_error();
      test_timeout();
      test_reset_mid_access();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
